// File: rtl/order_ingress_arbiter.sv
// order_ingress_arbiter: round-robin share of the order-manager entry port with post-transfer gap and order-ID stamping.
// Optional per-requester token-bucket throttle enabled by defining ORDER_ARB_THROTTLE_EN.
module order_ingress_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SYMBOL_WIDTH  = 32,
  parameter int PRICE_WIDTH   = 32,
  parameter int VOLUME_WIDTH  = 32,
  parameter int ISSUE_GAP     = 2,
  parameter int TOKEN_MAX     = 8,
  parameter int REFILL_PERIOD = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*SYMBOL_WIDTH-1:0]  req_symbol,
  input  logic [NUM_REQ*PRICE_WIDTH-1:0]   req_price,
  input  logic [NUM_REQ*VOLUME_WIDTH-1:0]  req_volume,
  input  logic [NUM_REQ-1:0]               req_side,
  input  logic [NUM_REQ*3-1:0]             req_type,
  output logic                             om_order_valid,
  input  logic                             om_order_ready,
  output logic [SYMBOL_WIDTH-1:0]          om_order_symbol,
  output logic [PRICE_WIDTH-1:0]           om_order_price,
  output logic [VOLUME_WIDTH-1:0]          om_order_volume,
  output logic                             om_order_side,
  output logic [2:0]                       om_order_type,
  output logic [31:0]                      om_order_id,
  output logic [31:0]                      grant_count,
  output logic [NUM_REQ-1:0]               throttle_mask
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [3:0] GAP_LOAD = 4'(ISSUE_GAP == 0 ? 0 : ISSUE_GAP - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;
  state_e                  state_q;
  logic [IW-1:0]           rr_ptr_q, win;
  logic [3:0]              gap_q;
  logic [23:0]             seq_q;
  logic [31:0]             grant_count_q, id_q;
  logic                    valid_q, side_q;
  logic [SYMBOL_WIDTH-1:0] symbol_q;
  logic [PRICE_WIDTH-1:0]  price_q;
  logic [VOLUME_WIDTH-1:0] volume_q;
  logic [2:0]              type_q;
  logic [NUM_REQ-1:0]      eligible;
  logic                    accept;
  assign eligible = req_valid & ~throttle_mask;
  // Scan downward so the last hit is the nearest eligible index at or after rr_ptr.
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (eligible[(int'(rr_ptr_q) + i) % NUM_REQ]) win = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
  end
  assign accept    = rst_n && state_q == IDLE && |eligible;
  assign req_ready = accept ? NUM_REQ'(1) << win : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gap_q         <= '0;
      seq_q         <= '0;
      grant_count_q <= '0;
      id_q          <= '0;
      valid_q       <= 1'b0;
      symbol_q      <= '0;
      price_q       <= '0;
      volume_q      <= '0;
      side_q        <= 1'b0;
      type_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q  <= ISSUE;
          valid_q  <= 1'b1;
          id_q     <= {8'(win), seq_q};
          symbol_q <= req_symbol[int'(win)*SYMBOL_WIDTH +: SYMBOL_WIDTH];
          price_q  <= req_price[int'(win)*PRICE_WIDTH +: PRICE_WIDTH];
          volume_q <= req_volume[int'(win)*VOLUME_WIDTH +: VOLUME_WIDTH];
          side_q   <= req_side[win];
          type_q   <= req_type[int'(win)*3 +: 3];
        end
        ISSUE: if (om_order_ready) begin
          state_q       <= ISSUE_GAP == 0 ? IDLE : GAP;
          valid_q       <= 1'b0;
          seq_q         <= seq_q + 24'd1;
          grant_count_q <= grant_count_q + 32'd1;
          rr_ptr_q      <= int'(id_q[24 +: IW]) == NUM_REQ - 1 ? '0 : id_q[24 +: IW] + IW'(1);
          gap_q         <= GAP_LOAD;
        end
        GAP: begin
          gap_q <= gap_q - 4'd1;
          if (gap_q == 4'd0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign om_order_valid  = valid_q;
  assign om_order_symbol = symbol_q;
  assign om_order_price  = price_q;
  assign om_order_volume = volume_q;
  assign om_order_side   = side_q;
  assign om_order_type   = type_q;
  assign om_order_id     = id_q;
  assign grant_count     = grant_count_q;
`ifdef ORDER_ARB_THROTTLE_EN
  localparam int TW = $clog2(TOKEN_MAX + 1);
  localparam int RW = $clog2(REFILL_PERIOD + 1);
  logic [RW-1:0] refill_cnt_q;
  logic [TW-1:0] tokens_q [NUM_REQ];
  logic          refill;
  assign refill = refill_cnt_q == RW'(REFILL_PERIOD - 1);
  // Refill and consume on the same bucket cancel; a full bucket takes no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_cnt_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) tokens_q[k] <= TW'(TOKEN_MAX);
    end else begin
      refill_cnt_q <= refill ? '0 : refill_cnt_q + RW'(1);
      for (int k = 0; k < NUM_REQ; k++)
        tokens_q[k] <= tokens_q[k] + TW'(refill && tokens_q[k] != TW'(TOKEN_MAX)) - TW'(req_ready[k]);
    end
  end
  always_comb begin
    throttle_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) throttle_mask[k] = tokens_q[k] == '0;
  end
`else
  logic unused_cfg;
  assign unused_cfg    = ^{32'(TOKEN_MAX), 32'(REFILL_PERIOD)};
  assign throttle_mask = '0;
`endif
endmodule

// File: tb/tb_order_ingress_arbiter.sv
// tb_order_ingress_arbiter: directed and randomized checks of order_ingress_arbiter
// against a cycle-level behavioural model (acceptance window, round-robin pick, buckets).
module tb_order_ingress_arbiter;
  localparam int NR = 4, GAPC = 2, TM = 8, RP = 16, W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0, req_side = '0;
  logic [NR-1:0] req_ready, throttle_mask;
  logic [NR*W-1:0] req_symbol = '0, req_price = '0, req_volume = '0;
  logic [NR*3-1:0] req_type = '0;
  logic om_order_valid, om_order_side, om_order_ready = 1'b0;
  logic [W-1:0] om_order_symbol, om_order_price, om_order_volume;
  logic [2:0] om_order_type;
  logic [31:0] om_order_id, grant_count;
  int total = 0, bad = 0;
  bit chk_on = 0;

  order_ingress_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_symbol(req_symbol), .req_price(req_price), .req_volume(req_volume),
    .req_side(req_side), .req_type(req_type),
    .om_order_valid(om_order_valid), .om_order_ready(om_order_ready),
    .om_order_symbol(om_order_symbol), .om_order_price(om_order_price),
    .om_order_volume(om_order_volume), .om_order_side(om_order_side),
    .om_order_type(om_order_type), .om_order_id(om_order_id),
    .grant_count(grant_count), .throttle_mask(throttle_mask)
  );

  always #5 clk = ~clk;

  // Model: an order is pending or not; acceptance is allowed from cycle m_next onward.
  bit m_pend;
  int m_w, m_rr, m_next, m_cyc;
  logic [23:0] m_seq;
  logic [31:0] m_gc, e_id, e_sym, e_pri, e_vol;
  logic e_side;
  logic [2:0] e_typ;
`ifdef ORDER_ARB_THROTTLE_EN
  int tok [NR];
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] exp_mask();
    logic [NR-1:0] m;
    m = '0;
`ifdef ORDER_ARB_THROTTLE_EN
    for (int k = 0; k < NR; k++) m[k] = tok[k] == 0;
`endif
    return m;
  endfunction

  function automatic int exp_winner();
    logic [NR-1:0] el;
    int k;
    el = req_valid & ~exp_mask();
    if (m_pend || m_cyc < m_next) return -1;
    for (int o = 0; o < NR; o++) begin
      k = (m_rr + o) % NR;
      if (el[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int k;
    k = exp_winner();
    if (k < 0) return '0;
    return NR'(1) << k;
  endfunction

  task automatic m_reset();
    m_pend = 0; m_w = 0; m_rr = 0; m_next = 0; m_cyc = 0;
    m_seq = '0; m_gc = '0; e_id = '0; e_sym = '0; e_pri = '0; e_vol = '0; e_side = 0; e_typ = '0;
`ifdef ORDER_ARB_THROTTLE_EN
    for (int k = 0; k < NR; k++) tok[k] = TM;
`endif
  endtask

  task automatic model_step();
    int k;
`ifdef ORDER_ARB_THROTTLE_EN
    bit refill;
    refill = (m_cyc % RP) == RP - 1;
`endif
    k = exp_winner();
`ifdef ORDER_ARB_THROTTLE_EN
    for (int j = 0; j < NR; j++) tok[j] += ((refill && tok[j] < TM) ? 1 : 0) - (j == k ? 1 : 0);
`endif
    if (k >= 0) begin
      m_pend = 1; m_w = k; e_id = {8'(k), m_seq};
      e_sym = req_symbol[k*W +: W]; e_pri = req_price[k*W +: W]; e_vol = req_volume[k*W +: W];
      e_side = req_side[k]; e_typ = req_type[k*3 +: 3];
    end else if (m_pend && om_order_ready) begin
      m_pend = 0; m_seq++; m_gc++; m_rr = (m_w + 1) % NR; m_next = m_cyc + 1 + GAPC;
    end
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #2;
  endtask

  task automatic do_reset();
    chk_on = 0; rst_n = 0; m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk_on = 1;
  endtask

  task automatic rand_payload();
    req_symbol = {$urandom, $urandom, $urandom, $urandom};
    req_price  = {$urandom, $urandom, $urandom, $urandom};
    req_volume = {$urandom, $urandom, $urandom, $urandom};
    req_side   = NR'($urandom);
    req_type   = (NR*3)'($urandom);
  endtask

  always @(negedge clk) if (chk_on && rst_n) begin
    chk("req_ready", req_ready, exp_ready());
    chk("om_valid", om_order_valid, m_pend);
    chk("grant_count", grant_count, m_gc);
    chk("throttle_mask", throttle_mask, exp_mask());
    if (m_pend) begin
      chk("om_id", om_order_id, e_id);
      chk("om_symbol", om_order_symbol, e_sym);
      chk("om_price", om_order_price, e_pri);
      chk("om_volume", om_order_volume, e_vol);
      chk("om_side", om_order_side, e_side);
      chk("om_type", om_order_type, e_typ);
    end
  end

  initial begin
    logic [31:0] ids [5];
    logic [W-1:0] p_sym, p_pri, p_vol;
    int n, acc;
    bit seen;
    m_reset();
    req_valid = '1; om_order_ready = 1;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", om_order_valid, 0);
    chk("rst_gc", grant_count, 0);
    chk("rst_id", om_order_id, 0);
    chk("rst_symbol", om_order_symbol, 0);
    chk("rst_mask", throttle_mask, 0);
    req_valid = '0;
    do_reset();
    // single request from requester 2
    rand_payload();
    req_valid = 4'b0100; om_order_ready = 1; #1;
    chk("sr_ready", req_ready, 4'b0100);
    step(); chk("sr_valid", om_order_valid, 1); chk("sr_id", om_order_id, 32'h0200_0000);
    step(); chk("sr_gap1", {om_order_valid, req_ready}, 0);
    step(); chk("sr_gap2", req_ready, 0);
    step(); chk("sr_again", req_ready, 4'b0100);
    step(); chk("sr_id2", om_order_id, 32'h0200_0001);
    req_valid = '0;
    repeat (4) step();
    // round-robin fairness from a fresh reset
    do_reset();
    req_valid = '1; n = 0;
    for (int g = 0; g < 40 && n < 5; g++) begin
      step();
      if (om_order_valid) begin ids[n] = om_order_id; n++; end
    end
    req_valid = '0;
    step();
    chk("rr_n", n, 5);
    chk("rr_gc", grant_count, 5);
    for (int i = 0; i < 5; i++) chk("rr_id", ids[i], {8'(i % NR), 24'(i)});
    repeat (3) step();
    // back-pressure: payload must hold while ready is low
    om_order_ready = 0; rand_payload(); req_valid = 4'b0001;
    p_sym = req_symbol[W-1:0]; p_pri = req_price[W-1:0]; p_vol = req_volume[W-1:0];
    step();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      rand_payload(); step();
      chk("bp_valid", om_order_valid, 1);
      chk("bp_payload", {om_order_symbol, om_order_price, om_order_volume}, {p_sym, p_pri, p_vol});
    end
    om_order_ready = 1; step();
    chk("bp_done", om_order_valid, 0);
    req_valid = '1; #1;
    chk("bp_gap1", req_ready, 0);
    step(); chk("bp_gap2", req_ready, 0);
    step(); chk("bp_next", req_ready, 4'b0010);
    req_valid = '0;
    step();
    // sequence wrap
    force dut.seq_q = 24'hFF_FFFF;
    #1 release dut.seq_q;
    m_seq = 24'hFF_FFFF;
    req_valid = 4'b0010;
    step(); chk("wrap_id0", om_order_id, 32'h01FF_FFFF);
    req_valid = '0;
    repeat (3) step();
    req_valid = 4'b0010;
    step(); chk("wrap_id1", om_order_id, 32'h0100_0000);
    req_valid = '0;
    repeat (3) step();
    // async reset while an order is held
    om_order_ready = 0; req_valid = 4'b1000;
    step(); #1;
    chk("ar_pre", om_order_valid, 1);
    chk_on = 0; rst_n = 0; m_reset(); #1;
    chk("ar_valid", om_order_valid, 0);
    chk("ar_gc", grant_count, 0);
    @(negedge clk); rst_n = 1;
    #1 chk_on = 1; om_order_ready = 1;
    step(); chk("ar_id", om_order_id, 32'h0300_0000);
    req_valid = '0;
    // one requester flooding
    do_reset();
    req_valid = 4'b0001; om_order_ready = 1; acc = 0; seen = 0; #1;
    for (int i = 0; i < 200; i++) begin
      acc += int'(req_ready[0]);
      seen |= throttle_mask[0];
      step();
    end
`ifdef ORDER_ARB_THROTTLE_EN
    chk("thr_acc", acc, 20);
    chk("thr_seen", seen, 1);
`else
    chk("thr_acc", acc, 50);
    chk("thr_seen", seen, 0);
`endif
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      req_valid = (i % 1000 < 500) ? NR'($urandom) : NR'($urandom & $urandom);
      om_order_ready = $urandom_range(0, 3) != 0;
      rand_payload();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
